eth_idma_sched: RTL and testbench
=================================

ETH_IDMA_SCHED -- requirements
Module: eth_idma_sched

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, width of descriptor and request addresses.
REQ-002 SHALL have parameter TFLenWidth, default 32, width of transfer length.
REQ-003 SHALL have parameter MaxOutstanding, default 2 (legal 1..8), maximum granted-but-uncompleted iDMA transfers.
REQ-004 SHALL have port clk_i  input  1  single clock for all logic.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tx_valid_i  input  1  TX descriptor valid (memory to Ethernet stream).
REQ-007 SHALL have port tx_ready_o  output  1  TX descriptor accepted.
REQ-008 SHALL have port tx_addr_i  input  AddrWidth  TX source memory address.
REQ-009 SHALL have port tx_len_i  input  TFLenWidth  TX length in bytes.
REQ-010 SHALL have port rx_valid_i  input  1  RX descriptor valid (Ethernet stream to memory).
REQ-011 SHALL have port rx_ready_o  output  1  RX descriptor accepted.
REQ-012 SHALL have port rx_addr_i  input  AddrWidth  RX destination memory address.
REQ-013 SHALL have port rx_len_i  input  TFLenWidth  RX length in bytes.
REQ-014 SHALL have port req_valid_o  output  1  iDMA backend request valid.
REQ-015 SHALL have port req_ready_i  input  1  iDMA backend request ready.
REQ-016 SHALL have port mem_addr_o  output  AddrWidth  memory-side address of the issued request.
REQ-017 SHALL have port len_o  output  TFLenWidth  length of the issued request.
REQ-018 SHALL have port dir_o  output  1  1 = TX (AXI read, AXIS write), 0 = RX (AXIS read, AXI write).
REQ-019 SHALL have port rsp_valid_i  input  1  iDMA response valid.
REQ-020 SHALL have port rsp_ready_o  output  1  iDMA response ready.
REQ-021 SHALL have port rsp_err_i  input  1  iDMA response carries an error.
REQ-022 SHALL have port tx_done_o, rx_done_o  output  1 each  one-cycle completion pulses.
REQ-023 SHALL have port err_o  output  1  sticky error; err_clr_i  input  1  clears err_o.
REQ-024 SHALL have port busy_o  output  1  outstanding count non-zero.

Function
REQ-025 SHALL grant a descriptor only when the output register is empty or being drained (req_valid_o & req_ready_i) and outstanding < MaxOutstanding; tx_ready_o/rx_ready_o are asserted combinationally in the grant cycle.
REQ-026 SHALL arbitrate round-robin when both valid: the last-granted direction loses; after reset TX wins first.
REQ-027 SHALL load the granted descriptor into the output register, asserting req_valid_o from the next cycle; mem_addr_o/len_o/dir_o SHALL stay stable until req_ready_i.
REQ-028 SHALL increment the outstanding counter on grant and decrement it on response handshake; both in the same cycle leaves it unchanged.
REQ-029 SHALL push dir into an in-order tag FIFO (depth MaxOutstanding) at request handshake and pop it at response handshake.
REQ-030 SHALL drive rsp_ready_o=1 while the tag FIFO is non-empty; rsp_valid_i with an empty FIFO SHALL be acknowledged (rsp_ready_o=1) and set err_o.
REQ-031 SHALL pulse tx_done_o or rx_done_o (per popped tag) one cycle after a response handshake with rsp_err_i=0; with rsp_err_i=1 SHALL set err_o and suppress the pulse.
REQ-032 SHALL give set priority over err_clr_i in the same cycle.

Reset
REQ-033 SHALL, on rst_ni low, asynchronously clear all state; every output is 0, the arbiter pointer favours TX, and the counter and FIFO are empty; responses arriving after a mid-operation reset SHALL be treated per REQ-030.

Configuration
REQ-034 SHALL, with ETH_IDMA_SCHED_ZEROLEN_EN defined, accept zero-length descriptors without issuing a request and pulse the matching done signal the next cycle; without the macro, zero-length descriptors SHALL be issued to iDMA like any other descriptor.

Verification
REQ-035 SHALL cover: TX only, addr 0x1000, len 64, req_ready_i=1 -> req_valid_o 1 cycle after grant, dir_o=1, tx_done_o 1 cycle after response.
REQ-036 SHALL cover: TX and RX held valid for 4 grants -> grant order TX, RX, TX, RX.
REQ-037 SHALL cover: MaxOutstanding=2, no responses -> third descriptor stalls with ready low and busy_o=1 until one response.
REQ-038 SHALL cover: rsp_err_i=1 on an RX response -> err_o=1 with no rx_done_o; err_clr_i with a simultaneous new error -> err_o stays 1.
REQ-039 SHALL cover: rsp_valid_i with no outstanding transfer -> err_o=1; reset asserted mid-transfer -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/eth_idma_sched.sv
// Ethernet iDMA descriptor scheduler: round-robin TX/RX grant, single request register,
// in-order tag FIFO for completions. Optional ETH_IDMA_SCHED_ZEROLEN_EN completes
// zero-length descriptors locally.
module eth_idma_sched #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned TFLenWidth     = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [AddrWidth-1:0]  tx_addr_i,
  input  logic [TFLenWidth-1:0] tx_len_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  input  logic [AddrWidth-1:0]  rx_addr_i,
  input  logic [TFLenWidth-1:0] rx_len_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [AddrWidth-1:0]  mem_addr_o,
  output logic [TFLenWidth-1:0] len_o,
  output logic                  dir_o,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic                  rsp_err_i,
  output logic                  tx_done_o,
  output logic                  rx_done_o,
  output logic                  err_o,
  input  logic                  err_clr_i,
  output logic                  busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic                  req_valid_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [TFLenWidth-1:0] len_q;
  logic                  dir_q;
  logic                  last_tx_q;
  logic [CntW-1:0]       out_cnt_q;
  logic [CntW-1:0]       fifo_cnt_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [MaxOutstanding-1:0] tag_q;
  logic                  tx_done_q, rx_done_q, err_q;

  logic can_grant, tx_pick, grant_tx, grant_rx, grant, issue;
  logic zl_tx, zl_rx;
  logic push, pop, fifo_empty, spurious, err_set, head_tag;

  // Reset gates the combinational readies so every output is 0 while rst_ni is low.
  assign can_grant = rst_ni & (~req_valid_q | req_ready_i) &
                     (out_cnt_q < CntW'(MaxOutstanding));
  // Last-granted direction loses when both are requesting.
  assign tx_pick   = tx_valid_i & (~rx_valid_i | ~last_tx_q);
  assign grant_tx  = can_grant & tx_pick;
  assign grant_rx  = can_grant & rx_valid_i & ~tx_pick;
  assign grant     = grant_tx | grant_rx;

`ifdef ETH_IDMA_SCHED_ZEROLEN_EN
  assign zl_tx = grant_tx & (tx_len_i == '0);
  assign zl_rx = grant_rx & (rx_len_i == '0);
`else
  assign zl_tx = 1'b0;
  assign zl_rx = 1'b0;
`endif
  assign issue = grant & ~zl_tx & ~zl_rx;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign push       = req_valid_q & req_ready_i;
  assign pop        = rsp_valid_i & ~fifo_empty;
  assign spurious   = rsp_valid_i & fifo_empty;
  assign head_tag   = tag_q[rd_ptr_q];
  assign err_set    = spurious | (pop & rsp_err_i);

  assign tx_ready_o  = grant_tx;
  assign rx_ready_o  = grant_rx;
  assign rsp_ready_o = rst_ni & (~fifo_empty | rsp_valid_i);
  assign req_valid_o = req_valid_q;
  assign mem_addr_o  = addr_q;
  assign len_o       = len_q;
  assign dir_o       = dir_q;
  assign tx_done_o   = tx_done_q;
  assign rx_done_o   = rx_done_q;
  assign err_o       = err_q;
  assign busy_o      = (out_cnt_q != '0);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      dir_q       <= 1'b0;
      last_tx_q   <= 1'b0;
    end else begin
      if (grant) begin
        last_tx_q <= grant_tx;
      end
      if (issue) begin
        req_valid_q <= 1'b1;
        addr_q      <= grant_tx ? tx_addr_i : rx_addr_i;
        len_q       <= grant_tx ? tx_len_i : rx_len_i;
        dir_q       <= grant_tx;
      end else if (push) begin
        req_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_q <= '0;
    end else if (issue && !pop) begin
      out_cnt_q <= out_cnt_q + 1'b1;
    end else if (pop && !issue) begin
      out_cnt_q <= out_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_q      <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= dir_q;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + 1'b1;
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tx_done_q <= (pop & ~rsp_err_i & head_tag) | zl_tx;
      rx_done_q <= (pop & ~rsp_err_i & ~head_tag) | zl_rx;
      // A new error wins over a simultaneous clear.
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_idma_sched.sv
// Self-checking bench for eth_idma_sched (default build, MaxOutstanding = 2).
module tb_eth_idma_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        tx_valid_i, tx_ready_o, rx_valid_i, rx_ready_o;
  logic [31:0] tx_addr_i, tx_len_i, rx_addr_i, rx_len_i;
  logic        req_valid_o, req_ready_i, dir_o;
  logic [31:0] mem_addr_o, len_o;
  logic        rsp_valid_i, rsp_ready_o, rsp_err_i;
  logic        tx_done_o, rx_done_o, err_o, err_clr_i, busy_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] len;
    logic        dir;
  } req_t;

  req_t exp_q[$];
  req_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pending = 0;
  int   tx_done_cnt = 0;
  int   rx_done_cnt = 0;
  bit   auto_rsp = 1'b0;

  eth_idma_sched #(
    .AddrWidth      (32),
    .TFLenWidth     (32),
    .MaxOutstanding (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tx_valid_i  (tx_valid_i),
    .tx_ready_o  (tx_ready_o),
    .tx_addr_i   (tx_addr_i),
    .tx_len_i    (tx_len_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .rx_addr_i   (rx_addr_i),
    .rx_len_i    (rx_len_i),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .mem_addr_o  (mem_addr_o),
    .len_o       (len_o),
    .dir_o       (dir_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_o (rsp_ready_o),
    .rsp_err_i   (rsp_err_i),
    .tx_done_o   (tx_done_o),
    .rx_done_o   (rx_done_o),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic req_t mk(input logic [31:0] addr, input logic [31:0] len, input logic dir);
    req_t r;
    r.addr = addr;
    r.len  = len;
    r.dir  = dir;
    return r;
  endfunction

  // Request monitor pops the scoreboard at each request handshake; counts completions.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (req_valid_o && req_ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("req_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("req_addr", mem_addr_o, mon_e.addr);
          check_eq("req_len", len_o, mon_e.len);
          check_eq("req_dir", dir_o, mon_e.dir);
        end
        pending++;
      end
      if (rsp_valid_i && rsp_ready_o && pending > 0) pending--;
      if (tx_done_o) tx_done_cnt++;
      if (rx_done_o) rx_done_cnt++;
    end
  end

  // Automatic in-order responder for streaming tests.
  always @(posedge clk_i) begin
    #1;
    if (auto_rsp) begin
      rsp_valid_i = (pending > 0);
      rsp_err_i   = 1'b0;
    end
  end

  task automatic do_reset();
    rst_ni      = 1'b0;
    auto_rsp    = 1'b0;
    tx_valid_i  = 1'b0;
    rx_valid_i  = 1'b0;
    tx_addr_i   = '0;
    tx_len_i    = '0;
    rx_addr_i   = '0;
    rx_len_i    = '0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_err_i   = 1'b0;
    err_clr_i   = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    pending     = 0;
    tx_done_cnt = 0;
    rx_done_cnt = 0;
    rst_ni      = 1'b1;
    tick();
  endtask

  task automatic send(input bit dir, input logic [31:0] addr, input logic [31:0] len);
    bit ok = 1'b0;
    if (dir) begin
      tx_valid_i = 1'b1; tx_addr_i = addr; tx_len_i = len;
    end else begin
      rx_valid_i = 1'b1; rx_addr_i = addr; rx_len_i = len;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (dir ? tx_ready_o : rx_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(dir ? "tx_grant_in_time" : "rx_grant_in_time", ok, 1);
    tick();
    if (dir) tx_valid_i = 1'b0;
    else     rx_valid_i = 1'b0;
  endtask

  task automatic respond(input bit err);
    rsp_valid_i = 1'b1;
    rsp_err_i   = err;
    @(negedge clk_i);
    check_eq("rsp_ready", rsp_ready_o, 1);
    tick();
    rsp_valid_i = 1'b0;
    rsp_err_i   = 1'b0;
  endtask

  initial begin
    // Reset state.
    do_reset();
    @(negedge clk_i);
    check_eq("rst_req_valid", req_valid_o, 0);
    check_eq("rst_tx_ready", tx_ready_o, 0);
    check_eq("rst_rx_ready", rx_ready_o, 0);
    check_eq("rst_rsp_ready", rsp_ready_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_done", {tx_done_o, rx_done_o}, 0);

    // Single TX transfer with timing.
    do_reset();
    req_ready_i = 1'b1;
    exp_q.push_back(mk(32'h1000, 32'd64, 1'b1));
    tx_valid_i = 1'b1; tx_addr_i = 32'h1000; tx_len_i = 32'd64;
    @(negedge clk_i);
    check_eq("t1_tx_ready", tx_ready_o, 1);
    check_eq("t1_req_valid_grant_cycle", req_valid_o, 0);
    tick();
    tx_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("t1_req_valid", req_valid_o, 1);
    check_eq("t1_dir", dir_o, 1);
    check_eq("t1_busy", busy_o, 1);
    tick();
    respond(1'b0);
    @(negedge clk_i);
    check_eq("t1_tx_done", tx_done_o, 1);
    check_eq("t1_rx_done", rx_done_o, 0);
    @(negedge clk_i);
    check_eq("t1_tx_done_pulse", tx_done_o, 0);
    check_eq("t1_busy_end", busy_o, 0);
    check_eq("t1_drain", exp_q.size(), 0);

    // Round-robin with both directions held valid.
    do_reset();
    req_ready_i = 1'b1;
    auto_rsp    = 1'b1;
    exp_q.push_back(mk(32'h2000, 32'd32, 1'b1));
    exp_q.push_back(mk(32'h3000, 32'd48, 1'b0));
    exp_q.push_back(mk(32'h2100, 32'd33, 1'b1));
    exp_q.push_back(mk(32'h3100, 32'd49, 1'b0));
    fork
      begin
        send(1'b1, 32'h2000, 32'd32);
        send(1'b1, 32'h2100, 32'd33);
      end
      begin
        send(1'b0, 32'h3000, 32'd48);
        send(1'b0, 32'h3100, 32'd49);
      end
    join
    repeat (15) tick();
    check_eq("rr_drain", exp_q.size(), 0);
    check_eq("rr_tx_done_cnt", tx_done_cnt, 2);
    check_eq("rr_rx_done_cnt", rx_done_cnt, 2);
    check_eq("rr_err", err_o, 0);
    check_eq("rr_busy_end", busy_o, 0);

    // Outstanding limit stalls the third descriptor.
    do_reset();
    req_ready_i = 1'b1;
    exp_q.push_back(mk(32'h4000, 32'd1, 1'b1));
    exp_q.push_back(mk(32'h4100, 32'd2, 1'b1));
    exp_q.push_back(mk(32'h4200, 32'd3, 1'b1));
    send(1'b1, 32'h4000, 32'd1);
    send(1'b1, 32'h4100, 32'd2);
    tx_valid_i = 1'b1; tx_addr_i = 32'h4200; tx_len_i = 32'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("lim_stall_ready", tx_ready_o, 0);
      check_eq("lim_stall_busy", busy_o, 1);
    end
    tick();
    respond(1'b0);
    @(negedge clk_i);
    check_eq("lim_release_ready", tx_ready_o, 1);
    tick();
    tx_valid_i = 1'b0;
    tick();
    respond(1'b0);
    respond(1'b0);
    repeat (2) tick();
    check_eq("lim_tx_done_cnt", tx_done_cnt, 3);
    check_eq("lim_drain", exp_q.size(), 0);
    check_eq("lim_busy_end", busy_o, 0);

    // Error response on RX, clear, and set-over-clear.
    do_reset();
    req_ready_i = 1'b1;
    exp_q.push_back(mk(32'h5000, 32'd16, 1'b0));
    send(1'b0, 32'h5000, 32'd16);
    repeat (2) tick();
    respond(1'b1);
    @(negedge clk_i);
    check_eq("err_set", err_o, 1);
    check_eq("err_no_rx_done", rx_done_o, 0);
    tick();
    check_eq("err_rx_done_cnt", rx_done_cnt, 0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    @(negedge clk_i);
    check_eq("err_cleared", err_o, 0);
    tick();
    exp_q.push_back(mk(32'h5100, 32'd17, 1'b0));
    send(1'b0, 32'h5100, 32'd17);
    repeat (2) tick();
    rsp_valid_i = 1'b1; rsp_err_i = 1'b1; err_clr_i = 1'b1;
    tick();
    rsp_valid_i = 1'b0; rsp_err_i = 1'b0; err_clr_i = 1'b0;
    @(negedge clk_i);
    check_eq("err_set_beats_clr", err_o, 1);

    // Response with nothing outstanding.
    do_reset();
    rsp_valid_i = 1'b1;
    @(negedge clk_i);
    check_eq("spur_rsp_ready", rsp_ready_o, 1);
    tick();
    rsp_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("spur_err", err_o, 1);

    // Reset in the middle of a transfer.
    do_reset();
    exp_q.push_back(mk(32'h6000, 32'd8, 1'b1));
    send(1'b1, 32'h6000, 32'd8);
    tx_valid_i = 1'b1; rx_valid_i = 1'b1;
    @(negedge clk_i);
    check_eq("mid_req_valid", req_valid_o, 1);
    #2;
    rst_ni      = 1'b0;
    rsp_valid_i = 1'b1;
    #1;
    check_eq("mid_rst_outputs",
             {req_valid_o, tx_ready_o, rx_ready_o, rsp_ready_o, busy_o, err_o, tx_done_o,
              rx_done_o, dir_o}, 0);
    check_eq("mid_rst_addr", mem_addr_o, 0);
    tx_valid_i = 1'b0; rx_valid_i = 1'b0; rsp_valid_i = 1'b0;
    exp_q.delete();
    tick();
    rst_ni = 1'b1;
    tick();
    rsp_valid_i = 1'b1;
    tick();
    rsp_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("post_rst_spur_err", err_o, 1);

    // Zero-length descriptor is issued like any other in the default build.
    do_reset();
    req_ready_i = 1'b1;
    auto_rsp    = 1'b1;
    exp_q.push_back(mk(32'h7000, 32'd0, 1'b0));
    send(1'b0, 32'h7000, 32'd0);
    repeat (6) tick();
    check_eq("zl_drain", exp_q.size(), 0);
    check_eq("zl_rx_done_cnt", rx_done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
